leaf_egress_arbiter: RTL and testbench
======================================

LEAF_EGRESS_ARBITER -- requirements
Module: leaf_egress_arbiter

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49: BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32: user payload width.
REQ-003 SHALL have parameters NUM_LEAF_BITS (5), NUM_PORT_BITS (4) and NUM_ADDR_BITS (7): destination leaf, destination port and BRAM address field widths.
REQ-004 SHALL have parameter NUM_OUT_PORTS, default 4: number of user output streams.
REQ-005 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64: credits returned per update.
REQ-006 SHALL have port clk, input, 1: single clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port din_leaf_user2interface, input, NUM_OUT_PORTS*PAYLOAD_BITS: per-stream payload, stream 0 in the LSBs.
REQ-009 SHALL have port vld_user2interface, input, NUM_OUT_PORTS: per-stream valid.
REQ-010 SHALL have port ack_interface2user, output, NUM_OUT_PORTS: per-stream accept.
REQ-011 SHALL have ports cfg_wr, cfg_sel and cfg_dest: input, 1 / log2(NUM_OUT_PORTS) / NUM_LEAF_BITS+NUM_PORT_BITS; write the destination table entry for stream cfg_sel.
REQ-012 SHALL have ports credit_upd and credit_sel: input, 1 / log2(NUM_OUT_PORTS); freespace return for stream credit_sel.
REQ-013 SHALL have port resend, input, 1: link stall/replay; suppresses all grants.
REQ-014 SHALL have port dout_leaf_interface2bft, output, PACKET_BITS: registered packet.

Function
REQ-015 Packet format SHALL be: [48] valid, [47:43] dest leaf, [42:39] dest port, [38:32] address, [31:0] payload.
REQ-016 Stream i SHALL be eligible iff vld[i]=1, credit[i]>0, resend=0 and the stream is configured (cfg_done[i]=1).
REQ-017 Arbitration SHALL be round-robin with priority starting at rr_ptr+1 modulo NUM_OUT_PORTS; at most one grant per cycle.
REQ-018 ack_interface2user[g] SHALL be asserted combinationally in the cycle stream g is granted; all other acks SHALL be 0.
REQ-019 A transfer SHALL occur when vld&ack; on the next clk edge dout SHALL carry valid=1, dest[g], wr_addr[g] and payload g (latency 1).
REQ-020 A cycle with no grant SHALL drive dout to all zeros on the next edge.
REQ-021 On a grant: rr_ptr:=g; wr_addr[g] SHALL increment, wrapping 2^NUM_ADDR_BITS-1 -> 0; credit[g] SHALL decrement.
REQ-022 credit_upd SHALL add FREESPACE_UPDATE_SIZE to credit[credit_sel], saturating at 2^NUM_ADDR_BITS.
REQ-023 A grant and a credit_upd on the same stream in the same cycle SHALL net to +FREESPACE_UPDATE_SIZE-1.
REQ-024 cfg_wr SHALL take effect on the next edge, set cfg_done[cfg_sel], and SHALL NOT alter wr_addr or credit.
REQ-025 resend=1 SHALL force all acks to 0, leave rr_ptr, wr_addr and credit unchanged, and drive dout to zero on the next edge.

Reset
REQ-026 On reset: dout=0, rr_ptr=NUM_OUT_PORTS-1 (stream 0 first), wr_addr=0, credit=2^NUM_ADDR_BITS, cfg_done=0, dest=0; acks SHALL be 0 while reset=1.
REQ-027 Reset asserted mid-stream SHALL discard any in-flight state; the first packet after release SHALL use address 0.

Configuration
REQ-028 Macro LEAF_EGRESS_STATS_EN SHALL, when defined, add output pkt_count (NUM_OUT_PORTS*16): per-stream granted-packet counters that reset to 0 and wrap at 16 bits.
REQ-029 When LEAF_EGRESS_STATS_EN is undefined, the port and the counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Configure streams 0..3 with dest (leaf 3, port 2); hold vld=4'b1111 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; stream 0's packets carry addresses 0 and 1; dout[47:39]=9'b00011_0010.
REQ-031 Stream 1 only, 128 packets with no credit_upd -> 128 acks, then ack stays 0; one credit_upd with sel=1 -> 64 further acks.
REQ-032 vld on an unconfigured stream 2 -> ack stays 0 and dout=0; after cfg_wr to stream 2, its ack goes high on the next cycle.
REQ-033 Pulse resend high for 3 cycles during continuous traffic -> no acks and dout=0 for those cycles; the round-robin order resumes where it left off.
REQ-034 Stream 0 sends 130 packets with credit refills -> addresses wrap 127 -> 0; grant and credit_upd in the same cycle give credit +63.
REQ-035 Assert reset after 5 packets -> dout=0 and acks=0; after release, the next packet uses address 0 and stream 0 wins first.

Source files
------------

// File: rtl/leaf_egress_arbiter.sv
// Leaf egress arbiter: round-robin merge of user streams into registered BFT packets,
// with per-stream destination table, write address and credit tracking.
// Optional per-stream packet counters are enabled by defining LEAF_EGRESS_STATS_EN.
module leaf_egress_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 4,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
  input  logic                                   cfg_wr,
  input  logic [$clog2(NUM_OUT_PORTS)-1:0]       cfg_sel,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
  input  logic                                   credit_upd,
  input  logic [$clog2(NUM_OUT_PORTS)-1:0]       credit_sel,
  input  logic                                   resend,
  output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft
`ifdef LEAF_EGRESS_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*16-1:0]            pkt_count
`endif
);

  localparam int SEL_BITS  = $clog2(NUM_OUT_PORTS);
  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam logic [CRED_BITS-1:0] CRED_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [CRED_BITS:0]   UPD      = (CRED_BITS+1)'(FREESPACE_UPDATE_SIZE);

  logic [NUM_OUT_PORTS-1:0] cfg_done_q, cfg_done_d;
  logic [DEST_BITS-1:0]     dest_q    [NUM_OUT_PORTS];
  logic [DEST_BITS-1:0]     dest_d    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wr_addr_q [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] wr_addr_d [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]     credit_q  [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]     credit_d  [NUM_OUT_PORTS];
  logic [SEL_BITS-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic                     grant_vld;
  logic [SEL_BITS-1:0]      grant_idx;
  logic [SEL_BITS-1:0]      idx;
  logic [PAYLOAD_BITS-1:0]  payload;
  logic [CRED_BITS:0]       sum;

  // Handshake: ack is a same-cycle accept; a beat transfers when vld & ack are both high.
  always_comb begin
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] && (credit_q[i] != '0) && cfg_done_q[i]
                    && !resend && !reset;
    end
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      idx = SEL_BITS'((32'(rr_ptr_q) + k) % NUM_OUT_PORTS);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    ack_interface2user = grant_vld ? (NUM_OUT_PORTS'(1) << grant_idx) : '0;
    payload = din_leaf_user2interface[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  always_comb begin
    cfg_done_d = cfg_done_q;
    rr_ptr_d   = grant_vld ? grant_idx : rr_ptr_q;
    dout_d     = '0;
    sum        = '0;
    if (grant_vld)
      dout_d = PACKET_BITS'({1'b1, dest_q[grant_idx], wr_addr_q[grant_idx], payload});
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      dest_d[i]    = dest_q[i];
      wr_addr_d[i] = wr_addr_q[i];
      sum          = {1'b0, credit_q[i]};
      if (grant_vld && grant_idx == SEL_BITS'(i)) begin
        wr_addr_d[i] = wr_addr_q[i] + NUM_ADDR_BITS'(1);
        sum          = sum - (CRED_BITS+1)'(1);
      end
      // Credit return is applied after the grant so a coincident pair nets to UPD-1.
      if (credit_upd && credit_sel == SEL_BITS'(i))
        sum = sum + UPD;
      credit_d[i] = (sum > {1'b0, CRED_MAX}) ? CRED_MAX : sum[CRED_BITS-1:0];
    end
    if (cfg_wr) begin
      dest_d[cfg_sel]     = cfg_dest;
      cfg_done_d[cfg_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q     <= '0;
      rr_ptr_q   <= SEL_BITS'(NUM_OUT_PORTS - 1);
      cfg_done_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i]    <= '0;
        wr_addr_q[i] <= '0;
        credit_q[i]  <= CRED_MAX;
      end
    end else begin
      dout_q     <= dout_d;
      rr_ptr_q   <= rr_ptr_d;
      cfg_done_q <= cfg_done_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_q[i]    <= dest_d[i];
        wr_addr_q[i] <= wr_addr_d[i];
        credit_q[i]  <= credit_d[i];
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;

`ifdef LEAF_EGRESS_STATS_EN
  logic [15:0] cnt_q [NUM_OUT_PORTS];
  logic [15:0] cnt_d [NUM_OUT_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_vld && grant_idx == SEL_BITS'(i))
        cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_cnt
    assign pkt_count[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_leaf_egress_arbiter.sv
// Directed bench for leaf_egress_arbiter: driver pushes the expected {ack, dout} per
// cycle into exp_q; an independent monitor pops and compares.
module tb_leaf_egress_arbiter;
  localparam int N  = 4;
  localparam int PB = 49;
  localparam int PL = 32;
  localparam int W  = N + PB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b1;
  logic [N*PL-1:0] din = '0;
  logic [N-1:0]    vld = '0;
  logic [N-1:0]    ack;
  logic            cfg_wr = 1'b0;
  logic [1:0]      cfg_sel = '0;
  logic [8:0]      cfg_dest = '0;
  logic            credit_upd = 1'b0;
  logic [1:0]      credit_sel = '0;
  logic            resend = 1'b0;
  logic [PB-1:0]   dout;
`ifdef LEAF_EGRESS_STATS_EN
  logic [N*16-1:0] pkt_count;
`endif

  leaf_egress_arbiter dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_wr                  (cfg_wr),
    .cfg_sel                 (cfg_sel),
    .cfg_dest                (cfg_dest),
    .credit_upd              (credit_upd),
    .credit_sel              (credit_sel),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
`ifdef LEAF_EGRESS_STATS_EN
    ,
    .pkt_count               (pkt_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int step_n = 0;
  int addr_m [N];
  logic [8:0] dest_m [N];

  logic       nx_reset = 1'b0, nx_cw = 1'b0, nx_cu = 1'b0, nx_rs = 1'b0;
  logic [1:0] nx_cwsel = '0, nx_cs = '0;
  logic [8:0] nx_cwdest = '0;

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] v, input int g);
    logic [N-1:0]  ea;
    logic [PB-1:0] ed;
    @(negedge clk);
    step_n++;
    reset      = nx_reset;
    resend     = nx_rs;
    cfg_wr     = nx_cw;
    cfg_sel    = nx_cwsel;
    cfg_dest   = nx_cwdest;
    credit_upd = nx_cu;
    credit_sel = nx_cs;
    vld        = v;
    for (int i = 0; i < N; i++) din[i*PL +: PL] = {8'(i + 1), 24'(step_n)};
    ea = '0;
    ed = '0;
    if (g >= 0) begin
      ea[g] = 1'b1;
      ed = {1'b1, dest_m[g], 7'(addr_m[g]), 8'(g + 1), 24'(step_n)};
      addr_m[g] = (addr_m[g] + 1) % 128;
    end
    exp_q.push_back({ea, ed});
    if (nx_reset) begin
      for (int i = 0; i < N; i++) begin
        addr_m[i] = 0;
        dest_m[i] = '0;
      end
    end else if (nx_cw) begin
      dest_m[nx_cwsel] = nx_cwdest;
    end
    nx_reset = 1'b0; nx_rs = 1'b0; nx_cw = 1'b0; nx_cu = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic [N-1:0] v);
    for (int i = 0; i < n; i++) begin
      nx_reset = 1'b1;
      step(v, -1);
    end
  endtask

  task automatic do_cfg(input logic [1:0] sel, input logic [8:0] d,
                        input logic [N-1:0] v, input int g);
    nx_cw = 1'b1; nx_cwsel = sel; nx_cwdest = d;
    step(v, g);
  endtask

  task automatic do_credit(input logic [1:0] sel, input logic [N-1:0] v, input int g);
    nx_cu = 1'b1; nx_cs = sel;
    step(v, g);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ack !== e[W-1:PB]) begin
          n_bad++;
          $display("FAIL ack t=%0t: got %b want %b", $time, ack, e[W-1:PB]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (dout !== e[PB-1:0]) begin
          n_bad++;
          $display("FAIL dout t=%0t: got %h want %h", $time, dout, e[PB-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [8:0] D32 = {5'd3, 4'd2};

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_m[i] = 0;
      dest_m[i] = '0;
    end

    // Reset with traffic pending: no acks, dout zero.
    do_reset(2, 4'b1111);
    // Nothing configured yet.
    step(4'b1111, -1);
    step(4'b1111, -1);
    for (int i = 0; i < N; i++) do_cfg(2'(i), D32, 4'b0000, -1);

    // Full load: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) step(4'b1111, i % 4);
    // Sparse requesters after rr_ptr=3.
    step(4'b0101, 0); step(4'b0101, 2); step(4'b0101, 0); step(4'b0101, 2);

    // Resend stall mid-traffic; order resumes at 3,0 | 1,2.
    step(4'b1111, 3);
    step(4'b1111, 0);
    for (int i = 0; i < 3; i++) begin
      nx_rs = 1'b1;
      step(4'b1111, -1);
    end
    step(4'b1111, 1);
    step(4'b1111, 2);

    // Reset mid-stream, reconfigure, stream 0 first at address 0.
    do_reset(2, 4'b1111);
    for (int i = 0; i < N; i++) do_cfg(2'(i), D32, 4'b0000, -1);
    step(4'b1111, 0);

    // Stream 1 alone: 128 credits, then starved, then one refill of 64.
    for (int i = 0; i < 128; i++) step(4'b0010, 1);
    step(4'b0010, -1);
    step(4'b0010, -1);
    do_credit(2'd1, 4'b0010, -1);
    for (int i = 0; i < 64; i++) step(4'b0010, 1);
    step(4'b0010, -1);

    // Stream 0: 127 credits left; 100 grants -> 27; grant+refill -> 90.
    for (int i = 0; i < 100; i++) step(4'b0001, 0);
    do_credit(2'd0, 4'b0001, 0);
    for (int i = 0; i < 90; i++) step(4'b0001, 0);
    step(4'b0001, -1);

    // Refill on a full stream saturates at 128.
    do_credit(2'd2, 4'b0000, -1);
    for (int i = 0; i < 128; i++) step(4'b0100, 2);
    step(4'b0100, -1);

    // Unconfigured stream 2 is ignored until its table entry is written.
    do_reset(1, 4'b0000);
    do_cfg(2'd0, {5'd1, 4'd1}, 4'b0000, -1);
    step(4'b0100, -1);
    step(4'b0100, -1);
    do_cfg(2'd2, {5'd5, 4'd9}, 4'b0100, -1);
    step(4'b0100, 2);
    step(4'b0101, 0);
    step(4'b0000, -1);

    // Drain and report.
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
